// File: rtl/mux_arbiter.sv
// Four-source round-robin arbiter that owns a W-bit output mux until the owner releases.
// Optional ownership timeout is compiled in with `define MUX_ARB_TIMEOUT_EN (limit set by TMO).
module mux_arbiter #(
   parameter int W   = 1,
   parameter int TMO = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   req,
   input  logic         done,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic         s1,
   output logic         s0,
   output logic [3:0]   gnt,
   output logic         busy,
   output logic [W-1:0] y,
   output logic         tmo
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t      state, state_nxt;
   logic [1:0]  ptr, ptr_nxt;
   logic [1:0]  sel, sel_nxt;
   logic [3:0]  gnt_nxt;
   logic [1:0]  winner;
   logic [1:0]  idx;
   logic        found;
   logic        release_now;
   logic        force_rel;

   // Search starts just past the last owner, so that owner ends up with lowest priority.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + k[1:0];
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign release_now = done || !req[sel];

`ifdef MUX_ARB_TIMEOUT_EN
   logic [7:0] cnt;

   assign force_rel = (state == OWN) && !release_now && (cnt == 8'(TMO - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'd0;
         tmo <= 1'b0;
      end else begin
         tmo <= force_rel;
         if (state == IDLE)
            cnt <= 8'd0;
         else
            cnt <= cnt + 8'd1;
      end
   end
`else
   assign force_rel = 1'b0;
   assign tmo       = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      gnt_nxt   = gnt;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = OWN;
               sel_nxt   = winner;
               gnt_nxt   = 4'b0001 << winner;
            end
         end
         OWN: begin
            // Select is left untouched on release; y is blanked by busy instead.
            if (release_now || force_rel) begin
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
               ptr_nxt   = sel;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= 2'd3;
         sel   <= 2'd0;
         gnt   <= 4'b0000;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel   <= sel_nxt;
         gnt   <= gnt_nxt;
      end
   end

   assign busy = (state == OWN);
   assign s1   = sel[1];
   assign s0   = sel[0];

   always_comb begin
      y = '0;
      if (busy) begin
         case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized traffic against
// a source-level ownership model; define MUX_ARB_TIMEOUT_EN to exercise the timeout build.
module tb_mux_arbiter;

   localparam int W     = 4;
   localparam int TMO_P = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [3:0]   req   = 4'b0000;
   logic         done  = 1'b0;
   logic [W-1:0] a, b, c, d;
   logic         s1, s0, busy, tmo;
   logic [3:0]   gnt;
   logic [W-1:0] y;

   int checks = 0;
   int errors = 0;

   mux_arbiter #(.W(W), .TMO(TMO_P)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .a(a), .b(b), .c(c), .d(d),
      .s1(s1), .s0(s0), .gnt(gnt), .busy(busy), .y(y), .tmo(tmo)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the bus, who owned it last, how long it has held it.
   int m_owner = -1;
   int m_last  = 3;
   int m_sel   = 0;
   int m_cnt   = 0;
   bit m_tmo   = 1'b0;
   int cand;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_last  = 3;
         m_sel   = 0;
         m_cnt   = 0;
         m_tmo   = 1'b0;
      end else begin
         m_tmo = 1'b0;
         if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
               cand = (m_last + k) % 4;
               if (m_owner < 0 && req[cand]) begin
                  m_owner = cand;
                  m_sel   = cand;
                  m_cnt   = 0;
               end
            end
         end else if (done || !req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
         end
`ifdef MUX_ARB_TIMEOUT_EN
         else if (m_cnt == TMO_P - 1) begin
            m_last  = m_owner;
            m_owner = -1;
            m_tmo   = 1'b1;
         end else begin
            m_cnt = m_cnt + 1;
         end
`endif
      end
   end

   function automatic logic [3:0] exp_gnt();
      return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
   endfunction

   function automatic logic [W-1:0] exp_y();
      if (m_owner < 0) return '0;
      case (m_sel)
         0:       return a;
         1:       return b;
         2:       return c;
         default: return d;
      endcase
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'b00 || y !== '0 || tmo !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: gnt=%b busy=%b sel=%b y=%h tmo=%b, expected all zero",
                  gnt, busy, {s1, s0}, y, tmo);
      end
      req = 4'b1111;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold: gnt=%b busy=%b, expected 0000/0", gnt, busy);
      end
      req = 4'b0000;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_single();
      a = 4'h1; b = 4'h2; c = 4'h4; d = 4'h8;
      req = 4'b0001;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || busy !== 1'b1 || y !== 4'h1) begin
         errors++;
         $display("[TB] FAIL single_grant: gnt=%b sel=%b busy=%b y=%h, expected 0001/00/1/1",
                  gnt, {s1, s0}, busy, y);
      end
      done = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || y !== '0) begin
         errors++;
         $display("[TB] FAIL single_release: gnt=%b busy=%b y=%h, expected 0000/0/0", gnt, busy, y);
      end
      done = 1'b0;
      req  = 4'b0000;
   endtask

   task automatic test_rotation();
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111;
      foreach (order[i]) begin
         @(posedge clk); #1;
         checks++;
         if (gnt !== 4'(1 << order[i]) || {s1, s0} !== 2'(order[i]) || busy !== 1'b1 ||
             y !== exp_y()) begin
            errors++;
            $display("[TB] FAIL rotation_grant %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%0d",
                     i, gnt, {s1, s0}, busy, 4'(1 << order[i]), order[i]);
         end
         done = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'(order[i]) || y !== '0) begin
            errors++;
            $display("[TB] FAIL rotation_idle %0d: gnt=%b busy=%b sel=%b y=%h, expected 0000/0/%0d/0",
                     i, gnt, busy, {s1, s0}, y, order[i]);
         end
         done = 1'b0;
      end
      req = 4'b0000;
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b0010;
      @(posedge clk); #1;
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      req  = 4'b0110;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0100 || {s1, s0} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL wrap_owner_c: gnt=%b sel=%b, expected 0100/10", gnt, {s1, s0});
      end
      req = 4'b0010;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_release: gnt=%b busy=%b, expected 0000/0", gnt, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0010 || {s1, s0} !== 2'b01 || y !== b) begin
         errors++;
         $display("[TB] FAIL wrap_regrant_b: gnt=%b sel=%b y=%h, expected 0010/01/%h",
                  gnt, {s1, s0}, y, b);
      end
      req = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_own();
      do_reset();
      req = 4'b1000;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b1000 || busy !== 1'b1 || y !== d) begin
         errors++;
         $display("[TB] FAIL midreset_grant: gnt=%b busy=%b y=%h, expected 1000/1/%h", gnt, busy, y, d);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || y !== '0 || tmo !== 1'b0 || {s1, s0} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL midreset_abort: gnt=%b busy=%b y=%h tmo=%b sel=%b, expected all zero",
                  gnt, busy, y, tmo, {s1, s0});
      end
      req = 4'b0000;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (tmo !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_after: tmo=%b busy=%b, expected 0/0", tmo, busy);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req  = 4'b0010;
      done = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      for (int i = 0; i < TMO_P; i++) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b1 || gnt !== 4'b0010 || tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_own %0d: busy=%b gnt=%b tmo=%b, expected 1/0010/0",
                     i, busy, gnt, tmo);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (tmo !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_pulse: tmo=%b gnt=%b busy=%b, expected 1/0000/0", tmo, gnt, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (tmo !== 1'b0 || gnt !== 4'b0010 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_regrant: tmo=%b gnt=%b busy=%b, expected 0/0010/1", tmo, gnt, busy);
      end
`else
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         checks++;
         if (gnt !== 4'b0010 || tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unbounded_own %0d: gnt=%b tmo=%b, expected 0010/0", i, gnt, tmo);
         end
      end
`endif
      req = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 4) == 0);
         a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
         @(posedge clk); #1;
         checks++;
         if (gnt !== exp_gnt() || busy !== (m_owner >= 0) || tmo !== m_tmo) begin
            errors++;
            $display("[TB] FAIL rand_ctrl %0d: gnt=%b busy=%b tmo=%b, expected %b/%b/%b",
                     i, gnt, busy, tmo, exp_gnt(), (m_owner >= 0), m_tmo);
         end
         checks++;
         if ({s1, s0} !== 2'(m_sel) || y !== exp_y()) begin
            errors++;
            $display("[TB] FAIL rand_data %0d: sel=%b y=%h, expected %0d/%h",
                     i, {s1, s0}, y, m_sel, exp_y());
         end
         checks++;
         if (!$onehot0(gnt)) begin
            errors++;
            $display("[TB] FAIL rand_onehot %0d: gnt=%b, expected one-hot or zero", i, gnt);
         end
      end
      req  = 4'b0000;
      done = 1'b0;
   endtask

   initial begin
      a = 4'h1; b = 4'h2; c = 4'h4; d = 4'h8;
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_reset_mid_own();
      test_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
